// File: rtl/meta_packet_align.sv
// Metadata/packet aligner: queues metadata words and attaches exactly one to the
// first beat of each AXI-Stream packet, stalling or flagging a miss when none is queued.
module meta_packet_align #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned META_W         = 32,
  parameter int unsigned DEPTH          = 8,
  parameter bit          STALL_ON_EMPTY = 1'b1,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         meta_in_valid,
  input  logic [META_W-1:0]            meta_in_data,
  output logic                         meta_in_ready,
  input  logic                         s_valid,
  input  logic [DATA_W-1:0]            s_data,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic                         m_valid,
  output logic [DATA_W-1:0]            m_data,
  output logic                         m_last,
  input  logic                         m_ready,
  output logic [META_W-1:0]            m_meta,
  output logic                         m_meta_valid,
  output logic                         m_sop,
  output logic [$clog2(DEPTH+1)-1:0]   meta_level,
  output logic [CNT_W-1:0]             pkt_count,
  output logic [CNT_W-1:0]             miss_count,
  output logic                         err_miss
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH+1);

  logic [META_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [LVL_W-1:0]  level_nxt;
  logic              full_r;
  logic              sop_r;
  logic              err_r;
  logic [CNT_W-1:0]  pkt_r;
  logic [CNT_W-1:0]  miss_r;

  logic empty;
  logic gate;
  logic xfer;
  logic push;
  logic pop;
  logic hit;
  logic miss;

  // Handshake and tagging decisions for the current beat
  assign empty = (level == '0);
  assign gate  = !(sop_r && empty && STALL_ON_EMPTY);
  assign xfer  = s_valid && gate && m_ready;
  assign push  = meta_in_valid && !full_r;
  assign pop   = xfer && sop_r && !empty;
  assign miss  = xfer && sop_r && empty;
  assign hit   = sop_r && !empty && s_valid;

  assign meta_in_ready = !full_r;
  assign m_valid       = s_valid && gate;
  assign s_ready       = m_ready && gate;
  assign m_data        = s_data;
  assign m_last        = s_last;
  assign m_sop         = sop_r;
  assign m_meta_valid  = hit;
  assign m_meta        = hit ? mem[rd_ptr] : '0;
  assign meta_level    = level;
  assign pkt_count     = pkt_r;
  assign miss_count    = miss_r;
  assign err_miss      = err_r;

  always_comb begin
    level_nxt = level;
    if (push && !pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (pop && !push) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  // Storage has no reset; only entries below the level are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= meta_in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full_r <= 1'b0;
      sop_r  <= 1'b1;
      err_r  <= 1'b0;
      pkt_r  <= '0;
      miss_r <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level  <= level_nxt;
      full_r <= (level_nxt == LVL_W'(DEPTH));
      if (xfer) begin
        sop_r <= s_last;
        if (s_last) begin
          pkt_r <= pkt_r + CNT_W'(1);
        end
      end
      if (miss) begin
        err_r <= 1'b1;
        if (miss_r != {CNT_W{1'b1}}) begin
          miss_r <= miss_r + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_meta_packet_align.sv
// Bench for meta_packet_align: a stalling and a non-stalling instance share stimulus;
// a queue-based model is compared every cycle, plus directed literal expectations.
module tb_meta_packet_align;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned META_W = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned LVL_W  = $clog2(DEPTH+1);

  logic clk = 1'b0;
  logic rst;
  logic meta_in_valid;
  logic [META_W-1:0] meta_in_data;
  logic s_valid;
  logic [DATA_W-1:0] s_data;
  logic s_last;
  logic m_ready;

  logic [1:0] meta_in_ready_w, s_ready_w, m_valid_w, m_last_w, m_meta_valid_w, m_sop_w, err_miss_w;
  logic [DATA_W-1:0] m_data_w [2];
  logic [META_W-1:0] m_meta_w [2];
  logic [LVL_W-1:0]  meta_level_w [2];
  logic [CNT_W-1:0]  pkt_count_w [2];
  logic [CNT_W-1:0]  miss_count_w [2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit bp = 1'b0;

  always #5 clk = ~clk;

  meta_packet_align #(.DATA_W(DATA_W), .META_W(META_W), .DEPTH(DEPTH), .STALL_ON_EMPTY(1'b1), .CNT_W(CNT_W)) u_stall (
    .clk(clk), .rst(rst),
    .meta_in_valid(meta_in_valid), .meta_in_data(meta_in_data), .meta_in_ready(meta_in_ready_w[0]),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready_w[0]),
    .m_valid(m_valid_w[0]), .m_data(m_data_w[0]), .m_last(m_last_w[0]), .m_ready(m_ready),
    .m_meta(m_meta_w[0]), .m_meta_valid(m_meta_valid_w[0]), .m_sop(m_sop_w[0]),
    .meta_level(meta_level_w[0]), .pkt_count(pkt_count_w[0]), .miss_count(miss_count_w[0]),
    .err_miss(err_miss_w[0])
  );

  meta_packet_align #(.DATA_W(DATA_W), .META_W(META_W), .DEPTH(DEPTH), .STALL_ON_EMPTY(1'b0), .CNT_W(CNT_W)) u_pass (
    .clk(clk), .rst(rst),
    .meta_in_valid(meta_in_valid), .meta_in_data(meta_in_data), .meta_in_ready(meta_in_ready_w[1]),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready_w[1]),
    .m_valid(m_valid_w[1]), .m_data(m_data_w[1]), .m_last(m_last_w[1]), .m_ready(m_ready),
    .m_meta(m_meta_w[1]), .m_meta_valid(m_meta_valid_w[1]), .m_sop(m_sop_w[1]),
    .meta_level(meta_level_w[1]), .pkt_count(pkt_count_w[1]), .miss_count(miss_count_w[1]),
    .err_miss(err_miss_w[1])
  );

  task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got %h expected %h", nm, inst, $time, act, exp);
    end
  endtask

  // Reference model: per instance, a queue of words, an SOP flag and counters
  logic [META_W-1:0] q0[$];
  logic [META_W-1:0] q1[$];
  bit               sop_m  [2];
  bit               err_m  [2];
  logic [CNT_W-1:0] pkt_m  [2];
  logic [CNT_W-1:0] miss_m [2];

  always begin
    logic [META_W-1:0] cur[$];
    bit emp, g, hit, xfer, was_full;
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        if (i == 0) cur = q0; else cur = q1;
        emp = (cur.size() == 0);
        g   = !(sop_m[i] && emp && (i == 0));
        hit = sop_m[i] && !emp && s_valid;
        chk("m_valid", i, 64'(m_valid_w[i]), 64'(s_valid && g));
        chk("s_ready", i, 64'(s_ready_w[i]), 64'(m_ready && g));
        chk("m_data", i, m_data_w[i], s_data);
        chk("m_last", i, 64'(m_last_w[i]), 64'(s_last));
        chk("m_sop", i, 64'(m_sop_w[i]), 64'(sop_m[i]));
        chk("m_meta_valid", i, 64'(m_meta_valid_w[i]), 64'(hit));
        chk("m_meta", i, 64'(m_meta_w[i]), hit ? 64'(cur[0]) : 64'd0);
        chk("meta_level", i, 64'(meta_level_w[i]), 64'(cur.size()));
        chk("meta_in_ready", i, 64'(meta_in_ready_w[i]), 64'(cur.size() != DEPTH));
        chk("pkt_count", i, 64'(pkt_count_w[i]), 64'(pkt_m[i]));
        chk("miss_count", i, 64'(miss_count_w[i]), 64'(miss_m[i]));
        chk("err_miss", i, 64'(err_miss_w[i]), 64'(err_m[i]));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) cur = q0; else cur = q1;
      if (rst) begin
        cur.delete();
        sop_m[i] = 1'b1; err_m[i] = 1'b0; pkt_m[i] = '0; miss_m[i] = '0;
      end else begin
        emp      = (cur.size() == 0);
        was_full = (cur.size() == DEPTH);
        g        = !(sop_m[i] && emp && (i == 0));
        xfer     = s_valid && g && m_ready;
        if (xfer && sop_m[i] && emp) begin
          err_m[i] = 1'b1;
          if (miss_m[i] != {CNT_W{1'b1}}) miss_m[i] = miss_m[i] + 1'b1;
        end
        if (xfer && sop_m[i] && !emp) void'(cur.pop_front());
        if (meta_in_valid && !was_full) cur.push_back(meta_in_data);
        if (xfer) begin
          if (s_last) pkt_m[i] = pkt_m[i] + 1'b1;
          sop_m[i] = s_last;
        end
      end
      if (i == 0) q0 = cur; else q1 = cur;
    end
    if (rst) chk_en = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [META_W-1:0] d);
    meta_in_valid = 1'b1;
    meta_in_data  = d;
    tick();
    meta_in_valid = 1'b0;
  endtask

  // Offer one beat until the target instance accepts it; report its tag
  task automatic send_beat(input int tgt, input logic [DATA_W-1:0] d, input bit last,
                           output bit mv, output logic [META_W-1:0] meta);
    bit got = 1'b0;
    mv = 1'b0; meta = '0;
    s_valid = 1'b1; s_data = d; s_last = last;
    for (int n = 0; n < 64 && !got; n++) begin
      @(negedge clk);
      if (s_ready_w[tgt] === 1'b1) begin
        got = 1'b1; mv = m_meta_valid_w[tgt]; meta = m_meta_w[tgt];
      end
      @(posedge clk);
      #1;
      if (bp) m_ready = ~m_ready;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("send_accept", tgt, 64'(got), 64'd1);
  endtask

  task automatic send_pkt(input int tgt, input int beats, input logic [DATA_W-1:0] base,
                          output bit mv, output logic [META_W-1:0] meta);
    bit tmv;
    logic [META_W-1:0] tmeta;
    for (int b = 0; b < beats; b++) begin
      send_beat(tgt, base + DATA_W'(b), b == beats - 1, tmv, tmeta);
      if (b == 0) begin mv = tmv; meta = tmeta; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit mv;
    logic [META_W-1:0] meta;
    rst = 1'b1; meta_in_valid = 1'b0; meta_in_data = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_meta_in_ready", 0, 64'(meta_in_ready_w[0]), 64'd1);
    chk("rst_m_valid", 0, 64'(m_valid_w[0]), 64'd0);
    chk("rst_m_meta_valid", 0, 64'(m_meta_valid_w[0]), 64'd0);
    chk("rst_m_meta", 0, 64'(m_meta_w[0]), 64'd0);
    chk("rst_level", 0, 64'(meta_level_w[0]), 64'd0);
    tick();

    // Basic tagging: 3-beat then 1-beat packet
    push(32'hA1);
    push(32'hB2);
    send_beat(0, 64'h1000, 1'b0, mv, meta);
    chk("p1_sop_mv", 0, 64'(mv), 64'd1);
    chk("p1_sop_meta", 0, 64'(meta), 64'hA1);
    send_beat(0, 64'h1001, 1'b0, mv, meta);
    chk("p1_b2_mv", 0, 64'(mv), 64'd0);
    send_beat(0, 64'h1002, 1'b1, mv, meta);
    chk("p1_b3_mv", 0, 64'(mv), 64'd0);
    send_beat(0, 64'h2000, 1'b1, mv, meta);
    chk("p2_sop_meta", 0, 64'(meta), 64'hB2);
    @(negedge clk);
    chk("p12_pkt_count", 0, 64'(pkt_count_w[0]), 64'd2);
    chk("p12_level", 0, 64'(meta_level_w[0]), 64'd0);
    tick();

    // Stall at SOP with empty FIFO
    s_valid = 1'b1; s_data = 64'h3000; s_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_s_ready", 0, 64'(s_ready_w[0]), 64'd0);
      chk("stall_m_valid", 0, 64'(m_valid_w[0]), 64'd0);
      tick();
    end
    meta_in_valid = 1'b1; meta_in_data = 32'hC3;
    @(negedge clk);
    chk("stall_push_cycle", 0, 64'(s_ready_w[0]), 64'd0);
    tick();
    meta_in_valid = 1'b0;
    @(negedge clk);
    chk("release_s_ready", 0, 64'(s_ready_w[0]), 64'd1);
    chk("release_meta", 0, 64'(m_meta_w[0]), 64'hC3);
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("release_level", 0, 64'(meta_level_w[0]), 64'd0);
    tick();

    // Pass-through misses on the non-stalling instance
    do_reset();
    send_pkt(1, 2, 64'h4000, mv, meta);
    chk("miss1_mv", 1, 64'(mv), 64'd0);
    chk("miss1_meta", 1, 64'(meta), 64'd0);
    send_pkt(1, 1, 64'h4100, mv, meta);
    chk("miss2_meta", 1, 64'(meta), 64'd0);
    @(negedge clk);
    chk("miss_err", 1, 64'(err_miss_w[1]), 64'd1);
    chk("miss_count", 1, 64'(miss_count_w[1]), 64'd2);
    chk("miss_err_stall_inst", 0, 64'(err_miss_w[0]), 64'd0);
    tick();
    push(32'hD4);
    send_pkt(1, 1, 64'h4200, mv, meta);
    chk("miss3_tag_mv", 1, 64'(mv), 64'd1);
    chk("miss3_tag_meta", 1, 64'(meta), 64'hD4);

    // Full FIFO, blocked push during pop, order across wrap
    do_reset();
    for (int k = 0; k < 8; k++) push(32'h100 + 32'(k));
    @(negedge clk);
    chk("full_ready", 0, 64'(meta_in_ready_w[0]), 64'd0);
    chk("full_level", 0, 64'(meta_level_w[0]), 64'd8);
    tick();
    meta_in_valid = 1'b1; meta_in_data = 32'hDEAD;
    s_valid = 1'b1; s_data = 64'h5000; s_last = 1'b1;
    @(negedge clk);
    chk("full_pop_ready", 0, 64'(meta_in_ready_w[0]), 64'd0);
    chk("full_pop_meta", 0, 64'(m_meta_w[0]), 64'h100);
    tick();
    meta_in_valid = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    @(negedge clk);
    chk("after_pop_level", 0, 64'(meta_level_w[0]), 64'd7);
    chk("after_pop_ready", 0, 64'(meta_in_ready_w[0]), 64'd1);
    tick();
    for (int p = 0; p < 20; p++) begin
      push(32'h108 + 32'(p));
      send_pkt(0, (p % 3) + 1, 64'h6000 + 64'(p * 16), mv, meta);
      chk("wrap_meta", 0, 64'(meta), 64'h101 + 64'(p));
    end

    // Backpressure on a 4-beat packet
    bp = 1'b1;
    send_pkt(0, 4, 64'h7000, mv, meta);
    bp = 1'b0; m_ready = 1'b1;
    chk("bp_meta", 0, 64'(meta), 64'h115);
    @(negedge clk);
    chk("bp_level", 0, 64'(meta_level_w[0]), 64'd6);
    chk("bp_pkt_count", 0, 64'(pkt_count_w[0]), 64'd22);
    tick();

    // Reset in the middle of a packet
    send_pkt(0, 1, 64'h8000, mv, meta);
    send_pkt(0, 1, 64'h8100, mv, meta);
    send_beat(0, 64'h8200, 1'b0, mv, meta);
    chk("mid_sop_meta", 0, 64'(meta), 64'h118);
    rst = 1'b1; s_valid = 1'b1; s_data = 64'h8201; s_last = 1'b0;
    tick();
    rst = 1'b0; s_data = 64'h8202;
    @(negedge clk);
    chk("mid_rst_level", 0, 64'(meta_level_w[0]), 64'd0);
    chk("mid_rst_pkt", 0, 64'(pkt_count_w[0]), 64'd0);
    chk("mid_rst_miss", 0, 64'(miss_count_w[0]), 64'd0);
    chk("mid_rst_err", 0, 64'(err_miss_w[0]), 64'd0);
    chk("mid_rst_sop", 0, 64'(m_sop_w[0]), 64'd1);
    chk("mid_rst_s_ready", 0, 64'(s_ready_w[0]), 64'd0);
    chk("mid_rst_m_valid", 0, 64'(m_valid_w[0]), 64'd0);
    tick();
    s_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/meta_packet_align.md
# meta_packet_align

Parametrised metadata/packet aligner in front of the SDNet packet processor. Buffers per-packet metadata words in a FIFO. Tracks start-of-packet on an AXI-Stream data path. Attaches exactly one metadata word to the first beat of every packet, either stalling the packet until metadata exists or passing it untagged and flagging the miss.

## Interface
Parameters:
- DATA_W, 64, stream data width in bits
- META_W, 32, metadata word width in bits
- DEPTH, 8, metadata FIFO entries; power of two, minimum 2
- STALL_ON_EMPTY, 1, 1 = hold the packet at SOP until metadata is available; 0 = pass the packet untagged and flag a miss
- CNT_W, 16, width of the packet and miss counters

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- meta_in_valid  in  1  metadata word offered
- meta_in_data  in  META_W  metadata word
- meta_in_ready  out  1  equals !full
- s_valid  in  1  input beat valid
- s_data  in  DATA_W  input beat data
- s_last  in  1  last beat of the packet
- s_ready  out  1  input beat accepted when s_valid && s_ready
- m_valid  out  1  output beat valid
- m_data  out  DATA_W  equals s_data, combinational
- m_last  out  1  equals s_last, combinational
- m_ready  in  1  downstream ready
- m_meta  out  META_W  metadata for the current SOP beat; 0 when m_meta_valid=0
- m_meta_valid  out  1  high only on an SOP beat that carries metadata
- m_sop  out  1  current beat is the first beat of a packet
- meta_level  out  $clog2(DEPTH+1)  FIFO occupancy
- pkt_count  out  CNT_W  packets completed (last beats transferred); wraps
- miss_count  out  CNT_W  SOP beats passed without metadata; saturates at all-ones
- err_miss  out  1  sticky; set on the first miss, cleared only by rst

## Operation
- Input accepted when s_valid && s_ready. Output transferred when m_valid && m_ready.
- FIFO:
  - Push on meta_in_valid && meta_in_ready. Pop on an SOP output transfer while not empty.
  - Simultaneous push and pop: the level is unchanged. The pointers wrap modulo DEPTH.
  - No bypass: a word pushed in cycle N can be used at SOP from cycle N+1.
- SOP state register sop_r:
  - Reset value 1.
  - On each output transfer: sop_r <= m_last. A last beat re-arms SOP; any other beat clears it.
  - m_sop = sop_r.
- Data path is combinational; no buffering of data beats. Define gate = !(sop_r && empty && STALL_ON_EMPTY). Then:
  - m_valid = s_valid && gate
  - s_ready = m_ready && gate
- SOP with FIFO not empty:
  - m_meta = FIFO head; m_meta_valid = 1.
  - Pop occurs on that beat's output transfer.
- SOP with FIFO empty, STALL_ON_EMPTY=1:
  - m_valid=0 and s_ready=0 until the level is ≥1. The beat then proceeds tagged.
- SOP with FIFO empty, STALL_ON_EMPTY=0:
  - The beat passes with m_meta_valid=0 and m_meta=0.
  - On the transfer: err_miss <= 1 and miss_count increments.
  - No metadata is consumed for that packet.
- Single-beat packet (SOP and last on the same beat): pops one word, and sop_r stays 1.
- Metadata never changes mid-packet. Only SOP beats read the head.
- pkt_count increments on every output transfer with m_last=1.

## Timing
- Reset values:
  - Internal: sop_r=1, FIFO empty, err_miss=0, pkt_count=0, miss_count=0.
  - Outputs with s_valid=0 and the FIFO empty: meta_in_ready=1, m_valid=0, m_meta_valid=0, m_meta=0, meta_level=0.
- rst mid-packet:
  - FIFO contents are discarded and sop_r returns to 1.
  - The next accepted beat is treated as SOP.
- Latency:
  - Data path: 0 cycles.
  - Metadata push to earliest use: 1 cycle.
  - Stall release: the cycle after the push that makes the level 1.
- Full FIFO: meta_in_ready=0. A pop in the same cycle does not raise meta_in_ready until the next cycle (registered full flag).
- Counters, meta_level and err_miss update on the clock edge after the qualifying event.

## Test plan
- Reset, then push meta 0xA1 and 0xB2, then send a 3-beat packet and a 1-beat packet with m_ready=1 -> the first SOP beat carries 0xA1; beats 2–3 have m_meta_valid=0; the 1-beat packet carries 0xB2; pkt_count=2; meta_level=0.
- STALL_ON_EMPTY=1, packet offered with the FIFO empty for 5 cycles, then push 0xC3 -> s_ready=0 and m_valid=0 for the 5 cycles (plus the push cycle); the SOP beat transfers the following cycle carrying 0xC3.
- STALL_ON_EMPTY=0, two packets with the FIFO empty -> both pass untagged with m_meta=0; err_miss=1; miss_count=2; a later push of 0xD4 tags the third packet.
- Fill the FIFO to DEPTH=8 -> meta_in_ready=0 and meta_level=8. Simultaneous push attempt and SOP pop -> level 7, the attempted word is not stored, and FIFO order is preserved across pointer wrap over 20 packets.
- Backpressure: m_ready toggled every cycle during a 4-beat packet -> one pop only; metadata held stable until the SOP transfer; no duplicate or dropped beats.
- Assert rst on beat 2 of a 4-beat packet with 3 words queued -> meta_level=0, counters 0, err_miss=0; the next beat is treated as SOP and stalls (STALL_ON_EMPTY=1).
